// File: rtl/core_dispatch_sched.sv
// Round-robin dispatcher that hands each FIFO execute request to one of two cores.
// It guards every run with a watchdog and keeps per-core completion counts.
module core_dispatch_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_en,
    input  logic [1:0]       core_ok,
    input  logic [1:0]       core_done,
    input  logic             clr_err,
    output logic [1:0]       core_en,
    output logic             sel,
    output logic             pin_di,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic [4:0] {
        StIdle    = 5'b00001,
        StGrant   = 5'b00010,
        StRun     = 5'b00100,
        StRelease = 5'b01000,
        StDrain   = 5'b10000
    } state_e;

    localparam logic [TO_W-1:0] WdLast = TO_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_sel;
    logic             r_rr;
    logic [1:0]       r_core_en;
    logic [TO_W-1:0]  r_wd;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic w_pick;
    logic w_dispatch;
    logic w_done;
    logic w_wd_last;
    logic w_run_exit;
    logic w_timeout;
    logic w_pin_di;
    logic w_busy;

    // Prefer the round-robin core; fall back to the other one if it is unavailable.
    assign w_pick     = core_ok[r_rr] ? r_rr : ~r_rr;
    assign w_dispatch = p_en & (|core_ok);
    assign w_done     = core_done[r_sel];
    assign w_wd_last  = (r_wd == WdLast);
    assign w_run_exit = (r_state == StRun) & (w_done | w_wd_last);
    assign w_timeout  = (r_state == StRun) & ~w_done & w_wd_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_dispatch) w_state_next = StGrant;
            StGrant:   w_state_next = StRun;
            StRun:     if (w_done || w_wd_last) w_state_next = StRelease;
            StRelease: w_state_next = StDrain;
            StDrain:   if (!p_en) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_pin_di = (r_state == StRelease);
        w_busy   = (r_state != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel     <= 1'b0;
            r_rr      <= 1'b0;
            r_core_en <= 2'b00;
            r_wd      <= '0;
            r_err     <= 1'b0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
        end else begin
            if (r_state == StIdle && w_dispatch) begin
                r_sel <= w_pick;
            end

            if (r_state == StGrant) begin
                r_core_en <= r_sel ? 2'b10 : 2'b01;
                r_wd      <= '0;
            end else if (r_state == StRun) begin
                r_wd <= r_wd + TO_W'(1);
                if (w_run_exit) begin
                    r_core_en <= 2'b00;
                end
            end

            // Completion is accounted on the RUN exit edge so counts are visible in RELEASE.
            if (w_run_exit) begin
                r_rr <= ~r_sel;
                if (w_done) begin
                    if (r_sel) r_cnt1 <= r_cnt1 + CNT_W'(1);
                    else       r_cnt0 <= r_cnt0 + CNT_W'(1);
                end
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign core_en     = r_core_en;
    assign sel         = r_sel;
    assign pin_di      = w_pin_di;
    assign busy        = w_busy;
    assign timeout_err = r_err;
    assign pkt_cnt0    = r_cnt0;
    assign pkt_cnt1    = r_cnt1;

endmodule

// File: tb/tb_core_dispatch_sched.sv
// Directed bench for core_dispatch_sched: a per-cycle vector table followed by
// hand-written watchdog, collision, stall and mid-run reset sequences.
module tb_core_dispatch_sched;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             p_en;
    logic [1:0]       core_ok;
    logic [1:0]       core_done;
    logic             clr_err;
    logic [1:0]       core_en;
    logic             sel;
    logic             pin_di;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] pkt_cnt0;
    logic [CNT_W-1:0] pkt_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    core_dispatch_sched #(
        .TIMEOUT_CYCLES(8),
        .TO_W          (16),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_en       (p_en),
        .core_ok    (core_ok),
        .core_done  (core_done),
        .clr_err    (clr_err),
        .core_en    (core_en),
        .sel        (sel),
        .pin_di     (pin_di),
        .busy       (busy),
        .timeout_err(timeout_err),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       p_en;
        logic [1:0] ok;
        logic [1:0] done;
        logic [1:0] en;
        logic       sel;
        logic       pin;
        logic       busy;
        int         cnt0;
        int         cnt1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int p, int ok, int dn, int en, int s, int pin, int bsy,
                                int c0, int c1);
        vec_t v;
        v.p_en = p[0];
        v.ok   = ok[1:0];
        v.done = dn[1:0];
        v.en   = en[1:0];
        v.sel  = s[0];
        v.pin  = pin[0];
        v.busy = bsy[0];
        v.cnt0 = c0;
        v.cnt1 = c1;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;

        // p_en, ok, done | core_en, sel, pin_di, busy, cnt0, cnt1 (after the edge)
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 3, 0, 1, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 3, 0, 1, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 3, 2, 1, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 3, 1, 0, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 3, 0, 0, 1, 0, 1, 1, 0));
        vq.push_back(mk(1, 3, 0, 2, 1, 0, 1, 1, 0));
        vq.push_back(mk(1, 3, 3, 0, 1, 1, 1, 1, 1));
        vq.push_back(mk(0, 3, 0, 0, 1, 0, 1, 1, 1));
        vq.push_back(mk(0, 3, 0, 0, 1, 0, 0, 1, 1));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 1, 1, 1));
        vq.push_back(mk(1, 3, 0, 1, 0, 0, 1, 1, 1));
        vq.push_back(mk(1, 3, 1, 0, 0, 1, 1, 2, 1));
        vq.push_back(mk(0, 3, 0, 0, 0, 0, 1, 2, 1));
        vq.push_back(mk(0, 3, 0, 0, 0, 0, 0, 2, 1));
        vq.push_back(mk(1, 3, 0, 0, 1, 0, 1, 2, 1));
        vq.push_back(mk(1, 3, 0, 2, 1, 0, 1, 2, 1));
        vq.push_back(mk(1, 3, 2, 0, 1, 1, 1, 2, 2));
        vq.push_back(mk(0, 3, 0, 0, 1, 0, 1, 2, 2));
        vq.push_back(mk(0, 3, 0, 0, 1, 0, 0, 2, 2));
        vq.push_back(mk(1, 2, 0, 0, 1, 0, 1, 2, 2));
        vq.push_back(mk(1, 2, 0, 2, 1, 0, 1, 2, 2));
        vq.push_back(mk(1, 2, 2, 0, 1, 1, 1, 2, 3));
        vq.push_back(mk(0, 2, 0, 0, 1, 0, 1, 2, 3));
        vq.push_back(mk(0, 2, 0, 0, 1, 0, 0, 2, 3));

        reset     = 1'b0;
        p_en      = 1'b0;
        core_ok   = 2'b00;
        core_done = 2'b00;
        clr_err   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_core_en", int'(core_en), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_pin_di", int'(pin_di), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(timeout_err), 0);
        chk("rst_cnt0", int'(pkt_cnt0), 0);
        chk("rst_cnt1", int'(pkt_cnt1), 0);

        foreach (vq[i]) begin
            p_en      = vq[i].p_en;
            core_ok   = vq[i].ok;
            core_done = vq[i].done;
            tick();
            chk($sformatf("v%0d_core_en", i), int'(core_en), int'(vq[i].en));
            chk($sformatf("v%0d_sel", i), int'(sel), int'(vq[i].sel));
            chk($sformatf("v%0d_pin_di", i), int'(pin_di), int'(vq[i].pin));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vq[i].busy));
            chk($sformatf("v%0d_cnt0", i), int'(pkt_cnt0), vq[i].cnt0);
            chk($sformatf("v%0d_cnt1", i), int'(pkt_cnt1), vq[i].cnt1);
            chk($sformatf("v%0d_err", i), int'(timeout_err), 0);
        end

        // No core available: request must stall in IDLE.
        p_en      = 1'b1;
        core_ok   = 2'b00;
        core_done = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_busy", int'(busy), 0);
            chk("stall_core_en", int'(core_en), 0);
            chk("stall_pin_di", int'(pin_di), 0);
        end

        // Watchdog abort with clr_err held high: the set must win.
        core_ok = 2'b11;
        clr_err = 1'b1;
        tick();
        chk("wd_sel", int'(sel), 0);
        tick();
        chk("wd_core_en", int'(core_en), 1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pin_di) begin
                lat = i;
                break;
            end
        end
        chk("wd_latency", lat, 8);
        chk("wd_err_set", int'(timeout_err), 1);
        chk("wd_core_en_off", int'(core_en), 0);
        chk("wd_cnt0", int'(pkt_cnt0), 2);
        chk("wd_cnt1", int'(pkt_cnt1), 3);
        clr_err = 1'b0;
        p_en    = 1'b0;
        tick();
        chk("wd_pin_single", int'(pin_di), 0);
        chk("wd_err_sticky", int'(timeout_err), 1);
        tick();
        chk("wd_idle", int'(busy), 0);
        clr_err = 1'b1;
        tick();
        chk("wd_err_clr", int'(timeout_err), 0);
        clr_err = 1'b0;

        // Done in the final watchdog cycle beats the timeout; stray done on core 1 ignored.
        p_en = 1'b1;
        tick();
        chk("col_sel", int'(sel), 1);
        tick();
        chk("col_core_en", int'(core_en), 2);
        core_done = 2'b01;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("col_stray_en", int'(core_en), 2);
            chk("col_stray_pin", int'(pin_di), 0);
        end
        core_done = 2'b10;
        tick();
        chk("col_pin_di", int'(pin_di), 1);
        chk("col_err", int'(timeout_err), 0);
        chk("col_cnt1", int'(pkt_cnt1), 4);
        chk("col_cnt0", int'(pkt_cnt0), 2);
        core_done = 2'b00;
        p_en      = 1'b0;
        tick();
        tick();
        chk("col_idle", int'(busy), 0);

        // Asynchronous reset while core 2 is running.
        p_en    = 1'b1;
        core_ok = 2'b10;
        tick();
        tick();
        chk("mrst_core_en_pre", int'(core_en), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_core_en", int'(core_en), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_sel", int'(sel), 0);
        chk("mrst_cnt0", int'(pkt_cnt0), 0);
        chk("mrst_cnt1", int'(pkt_cnt1), 0);
        p_en    = 1'b0;
        core_ok = 2'b11;
        tick();
        reset = 1'b1;
        p_en  = 1'b1;
        tick();
        chk("mrst_rr_sel", int'(sel), 0);
        chk("mrst_rr_busy", int'(busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/core_dispatch_sched.md
Name: core_dispatch_sched

Overview:
- Schedules per-packet processing between the two processor cores that share the dual packet FIFO.
- When the FIFO controller enters its execute phase and raises p_en, this block picks one core (round-robin among enabled cores), drives the memory-port select, and enables that core.
- It waits for the core's done signal, or a watchdog timeout, then returns a single-cycle pin_di pulse to the FIFO controller.
- It keeps per-core packet counts and a sticky timeout error.

Parameters:
- TIMEOUT_CYCLES, 1024: RUN-state cycles allowed before the watchdog aborts; valid range 2..2^TO_W-1.
- TO_W, 16: watchdog counter width.
- CNT_W, 16: width of each per-core packet counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- p_en  input  1  execute request from the FIFO controller; level, held high until it sees pin_di.
- core_ok  input  2  per-core availability mask (bit0 = core 1, bit1 = core 2); sampled only in IDLE.
- core_done  input  2  per-core completion, level or pulse; only the selected bit is honoured, and only in RUN.
- core_en  output  2  one-hot processor enable, registered.
- sel  output  1  memory-port / data-mux select (0 = core 1 FIFO, 1 = core 2 FIFO), registered.
- pin_di  output  1  one-cycle done pulse to the FIFO controller.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky watchdog flag.
- clr_err  input  1  synchronous clear of timeout_err.
- pkt_cnt0  output  CNT_W  packets completed normally by core 1.
- pkt_cnt1  output  CNT_W  packets completed normally by core 2.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs and counters go to 0: core_en=2'b00, sel=0, pin_di=0, timeout_err=0, pkt_cnt0/1=0.
  - The round-robin pointer rr goes to 0 (core 1 preferred) and state goes to IDLE.
  - core_en drops immediately, without waiting for a clock edge, when reset asserts mid-operation.
- States (one-hot): IDLE, GRANT, RUN, RELEASE, DRAIN.
- IDLE:
  - If p_en=1 and core_ok!=0:
    - pick = rr if core_ok[rr]=1, otherwise the other core;
    - register sel<=pick and go to GRANT.
  - If p_en=1 and core_ok=0: stay in IDLE with no dispatch; the FIFO controller stalls.
- GRANT:
  - Exactly one cycle, so the memory mux settles.
  - core_en<=onehot(sel) takes effect on entry to RUN; watchdog counter <=0.
  - Go to RUN.
- RUN:
  - Watchdog increments every cycle.
  - If core_done[sel]=1: go to RELEASE (normal completion).
  - Else if watchdog reaches TIMEOUT_CYCLES-1: set timeout_err and go to RELEASE (abort).
  - If done and the timeout boundary fall in the same cycle, done wins: no error, and the counter increments.
  - core_done on the unselected core is ignored.
- RELEASE:
  - Exactly one cycle: pin_di=1, core_en=2'b00.
  - On normal completion, pkt_cnt[sel] increments, wrapping modulo 2^CNT_W.
  - rr<=~sel, on both normal completion and abort.
  - Go to DRAIN.
- DRAIN:
  - Wait for p_en=0 (the FIFO controller has left execute), then go to IDLE.
  - This prevents double dispatch while the controller's registered done propagates.
- Latency:
  - p_en high in IDLE → sel valid after 1 clk → core_en high after 2 clk.
  - core_done → pin_di after 1 clk.
- Output timing: sel stays stable from GRANT through DRAIN and changes only on IDLE→GRANT.
- timeout_err priority: clr_err clears it; a set in the same cycle as clr_err wins.

Test Plan:
- Basic dispatch: reset, core_ok=2'b11, p_en=1 → sel=0 at cycle 1, core_en=2'b01 at cycle 2. Assert core_done=2'b01 at cycle 5 → pin_di=1 at cycle 6 only, pkt_cnt0=1, then DRAIN until p_en=0 → IDLE.
- Round-robin: three back-to-back packets with core_ok=2'b11 → sel sequence 0,1,0; pkt_cnt0=2, pkt_cnt1=1.
- Masking: core_ok=2'b10 with rr=0 → sel=1. core_ok=2'b00 with p_en=1 for 20 cycles → busy=0, core_en=0, no pin_di.
- Watchdog: TIMEOUT_CYCLES=8, no core_done → pin_di pulses 8 cycles after RUN entry, timeout_err=1, pkt_cnt unchanged. clr_err=1 → timeout_err=0 next cycle.
- Done/timeout collision and stray done:
  - core_done[sel] asserted in the final watchdog cycle → timeout_err stays 0, pkt_cnt increments.
  - core_done on the unselected core during RUN → ignored.
- Reset mid-RUN: reset low while core_en=2'b10 → core_en=0 asynchronously. After release → IDLE, counters 0, rr=0.
